// File: rtl/time_unit_counter_pkg.sv
// Shared constants and converter state type for the stopwatch time-unit counters.
package time_unit_pkg;
  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;
  localparam int BCD_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;
endpackage

// File: rtl/time_unit_counter_if.sv
// Strobe/count bundle between the stopwatch controller (master) and one time unit (slave).
// Optional load port pair appears when TIME_UNIT_COUNTER_LOAD_EN is defined.
interface time_unit_counter_if #(parameter int WIDTH = 7);
   import time_unit_pkg::*;

   // Strobes are single-cycle qualifiers with no ready: each high cycle is one step,
   // and carry/borrow answer combinationally in that same cycle.
   logic                 i_up;
   logic                 i_down;
   logic                 i_clear;
`ifdef TIME_UNIT_COUNTER_LOAD_EN
   logic                 i_load;
   logic [WIDTH-1:0]     i_load_value;
`endif
   logic [WIDTH-1:0]     o_value;
   logic                 o_carryup;
   logic                 o_borrow;
   logic [BCD_W-1:0]     o_tens;
   logic [BCD_W-1:0]     o_ones;
   logic                 o_bcd_valid;
   bcd_state_e           bcd_state;

   modport master (
      output i_up, i_down, i_clear,
`ifdef TIME_UNIT_COUNTER_LOAD_EN
      output i_load, i_load_value,
`endif
      input  o_value, o_carryup, o_borrow, o_tens, o_ones, o_bcd_valid, bcd_state
   );

   modport slave (
      input  i_up, i_down, i_clear,
`ifdef TIME_UNIT_COUNTER_LOAD_EN
      input  i_load, i_load_value,
`endif
      output o_value, o_carryup, o_borrow, o_tens, o_ones, o_bcd_valid, bcd_state
   );
endinterface

// File: rtl/time_unit_counter_bin2bcd_seq.sv
// Iterative shift-add-3 binary to two-digit BCD converter, one input bit per cycle.
module bin2bcd_seq
   import time_unit_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_value,
   output logic [BCD_W-1:0] o_tens,
   output logic [BCD_W-1:0] o_ones,
   output logic             o_valid,
   output bcd_state_e       o_state
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   bcd_state_e       state;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic [BCD_W-1:0] tens_s;
   logic [BCD_W-1:0] ones_s;
   logic [BCD_W-1:0] tens_adj;
   logic [BCD_W-1:0] ones_adj;

   always_comb begin
      tens_adj = (tens_s >= BCD_W'(5)) ? tens_s + BCD_W'(3) : tens_s;
      ones_adj = (ones_s >= BCD_W'(5)) ? ones_s + BCD_W'(3) : ones_s;
   end

   // A start in any state restarts from the new value; old digits are kept until DONE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         tens_s  <= '0;
         ones_s  <= '0;
         o_tens  <= '0;
         o_ones  <= '0;
         o_valid <= 1'b1;
      end else if (i_start) begin
         state   <= SHIFT;
         shreg   <= i_value;
         bit_cnt <= CNT_W'(WIDTH - 1);
         tens_s  <= '0;
         ones_s  <= '0;
         o_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: ;
            SHIFT: begin
               tens_s <= {tens_adj[BCD_W-2:0], ones_adj[BCD_W-1]};
               ones_s <= {ones_adj[BCD_W-2:0], shreg[bit_cnt]};
               if (bit_cnt == '0) state <= DONE;
               else               bit_cnt <= bit_cnt - 1'b1;
            end
            DONE: begin
               o_tens  <= tens_s;
               o_ones  <= ones_s;
               o_valid <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_state = state;
endmodule

// File: rtl/time_unit_counter.sv
// Modulo-(MAX+1) up/down time-unit counter with combinational carry/borrow and BCD readout.
// Build option: TIME_UNIT_COUNTER_LOAD_EN adds a clamped parallel load.
module time_unit_counter
   import time_unit_pkg::*;
#(
   parameter int MAX   = 59,
   parameter int WIDTH = 7
) (
   input  logic          i_clk,
   input  logic          i_rst,
   time_unit_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] MAX_M1  = WIDTH'(MAX - 1);

   logic [WIDTH-1:0] value;
   logic [WIDTH-1:0] value_next;
   logic             carry;
   logic             borrow;
   logic             start;

   // Earlier branches win, so carry/borrow are naturally gated by clear and load.
   always_comb begin
      value_next = value;
      carry      = 1'b0;
      borrow     = 1'b0;
      if (bus.i_clear) begin
         value_next = '0;
`ifdef TIME_UNIT_COUNTER_LOAD_EN
      end else if (bus.i_load) begin
         value_next = (bus.i_load_value > MAX_V) ? MAX_V : bus.i_load_value;
`endif
      end else if (bus.i_up && !bus.i_down) begin
         if (value >= MAX_V) begin
            value_next = '0;
            carry      = 1'b1;
         end else begin
            value_next = value + 1'b1;
         end
      end else if (bus.i_down && !bus.i_up) begin
         if (value == '0) begin
            value_next = MAX_V;
            borrow     = 1'b1;
         end else if (value > MAX_V) begin
            value_next = MAX_M1;
         end else begin
            value_next = value - 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) value <= '0;
      else       value <= value_next;
   end

   assign start = (value_next != value);

   bin2bcd_seq #(.WIDTH(WIDTH)) u_bcd (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (start),
      .i_value (value_next),
      .o_tens  (bus.o_tens),
      .o_ones  (bus.o_ones),
      .o_valid (bus.o_bcd_valid),
      .o_state (bus.bcd_state)
   );

   assign bus.o_value   = value;
   assign bus.o_carryup = carry;
   assign bus.o_borrow  = borrow;
endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench for time_unit_counter: wrap, borrow, hold, clear, reset, chaining and optional load.
module tb_time_unit_counter;
  import time_unit_pkg::*;

  logic i_clk;
  logic i_rst;
  int   n_tests;
  int   n_fail;
  int   hi_pulses;
  int   exp_lo;
  int   exp_hi;

  time_unit_counter_if #(.WIDTH(7)) u_if  ();
  time_unit_counter_if #(.WIDTH(7)) lo_if ();
  time_unit_counter_if #(.WIDTH(7)) hi_if ();

  time_unit_counter #(.MAX(59), .WIDTH(7)) dut    (.i_clk(i_clk), .i_rst(i_rst), .bus(u_if.slave));
  time_unit_counter #(.MAX(99), .WIDTH(7)) dut_lo (.i_clk(i_clk), .i_rst(i_rst), .bus(lo_if.slave));
  time_unit_counter #(.MAX(59), .WIDTH(7)) dut_hi (.i_clk(i_clk), .i_rst(i_rst), .bus(hi_if.slave));

  assign hi_if.i_up = lo_if.o_carryup;

`ifdef TIME_UNIT_COUNTER_LOAD_EN
  time_unit_counter_if #(.WIDTH(5)) ld_if ();
  time_unit_counter #(.MAX(23), .WIDTH(5)) dut_ld (.i_clk(i_clk), .i_rst(i_rst), .bus(ld_if.slave));
`endif

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    hi_pulses = 0;
    i_rst = 1'b1;
    u_if.i_up = 0;  u_if.i_down = 0;  u_if.i_clear = 0;
    lo_if.i_up = 0; lo_if.i_down = 0; lo_if.i_clear = 0;
    hi_if.i_down = 0; hi_if.i_clear = 0;
`ifdef TIME_UNIT_COUNTER_LOAD_EN
    u_if.i_load = 0;  u_if.i_load_value = '0;
    lo_if.i_load = 0; lo_if.i_load_value = '0;
    hi_if.i_load = 0; hi_if.i_load_value = '0;
    ld_if.i_up = 0; ld_if.i_down = 0; ld_if.i_clear = 0;
    ld_if.i_load = 0; ld_if.i_load_value = '0;
`endif
    tick();
    tick();
    i_rst = 1'b0;

    // reset state
    chk("rst_value", 32'(u_if.o_value), 0);
    chk("rst_tens",  32'(u_if.o_tens), 0);
    chk("rst_ones",  32'(u_if.o_ones), 0);
    chk("rst_valid", 32'(u_if.o_bcd_valid), 1);
    chk("rst_state", 32'(u_if.bcd_state), 32'(IDLE));

    // count up through the wrap
    u_if.i_up = 1;
    #1;
    for (int i = 0; i < 60; i++) begin
      chk("up_value", 32'(u_if.o_value), 32'(i));
      chk("up_carry", 32'(u_if.o_carryup), (i == 59) ? 1 : 0);
      chk("up_borrow", 32'(u_if.o_borrow), 0);
      if (i == 30) chk("up_stream_valid", 32'(u_if.o_bcd_valid), 0);
      tick();
    end
    u_if.i_up = 0;
    chk("wrap_value", 32'(u_if.o_value), 0);
    for (int k = 0; k < 7; k++) tick();
    chk("wrap_valid_early", 32'(u_if.o_bcd_valid), 0);
    tick();
    chk("wrap_valid", 32'(u_if.o_bcd_valid), 1);
    chk("wrap_tens",  32'(u_if.o_tens), 0);
    chk("wrap_ones",  32'(u_if.o_ones), 0);

    // borrow from 0
    u_if.i_down = 1;
    #1;
    chk("down_borrow", 32'(u_if.o_borrow), 1);
    chk("down_carry",  32'(u_if.o_carryup), 0);
    tick();
    u_if.i_down = 0;
    chk("down_value", 32'(u_if.o_value), 59);
    for (int k = 0; k < 8; k++) begin
      chk("down_valid_low", 32'(u_if.o_bcd_valid), 0);
      tick();
    end
    chk("down_valid", 32'(u_if.o_bcd_valid), 1);
    chk("down_tens",  32'(u_if.o_tens), 5);
    chk("down_ones",  32'(u_if.o_ones), 9);

    // both strobes freeze the unit
    u_if.i_up = 1;
    u_if.i_down = 1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_carry",  32'(u_if.o_carryup), 0);
      chk("hold_borrow", 32'(u_if.o_borrow), 0);
      tick();
      chk("hold_value",  32'(u_if.o_value), 59);
      chk("hold_valid",  32'(u_if.o_bcd_valid), 1);
    end
    u_if.i_down = 0;

    // clear beats up at MAX
    u_if.i_clear = 1;
    #1;
    chk("clr_carry", 32'(u_if.o_carryup), 0);
    tick();
    u_if.i_clear = 0;
    u_if.i_up = 0;
    chk("clr_value", 32'(u_if.o_value), 0);
    tick();
    tick();
    chk("clr_midconv_valid", 32'(u_if.o_bcd_valid), 0);
    chk("clr_midconv_tens",  32'(u_if.o_tens), 5);

    // reset in the middle of a conversion
    i_rst = 1;
    tick();
    i_rst = 0;
    chk("rst2_value", 32'(u_if.o_value), 0);
    chk("rst2_tens",  32'(u_if.o_tens), 0);
    chk("rst2_ones",  32'(u_if.o_ones), 0);
    chk("rst2_valid", 32'(u_if.o_bcd_valid), 1);
    chk("rst2_state", 32'(u_if.bcd_state), 32'(IDLE));

    // clear at 0 is not a change
    u_if.i_clear = 1;
    tick();
    u_if.i_clear = 0;
    chk("clr0_valid", 32'(u_if.o_bcd_valid), 1);
    chk("clr0_state", 32'(u_if.bcd_state), 32'(IDLE));

    // chained 99 -> 59 units, lower up held for 6000 cycles
    exp_lo = 0;
    exp_hi = 0;
    lo_if.i_up = 1;
    #1;
    for (int c = 0; c < 6000; c++) begin
      if (hi_if.o_carryup === 1'b1) hi_pulses++;
      tick();
      if (exp_lo == 99) begin
        exp_lo = 0;
        exp_hi = (exp_hi == 59) ? 0 : exp_hi + 1;
      end else begin
        exp_lo = exp_lo + 1;
      end
      chk("chain_lo", 32'(lo_if.o_value), 32'(exp_lo));
      chk("chain_hi", 32'(hi_if.o_value), 32'(exp_hi));
    end
    lo_if.i_up = 0;
    chk("chain_lo_end", 32'(lo_if.o_value), 0);
    chk("chain_hi_end", 32'(hi_if.o_value), 0);
    chk("chain_hi_pulses", 32'(hi_pulses), 1);

`ifdef TIME_UNIT_COUNTER_LOAD_EN
    // clamped load, no carry on a load cycle
    ld_if.i_load = 1;
    ld_if.i_load_value = 5'd30;
    ld_if.i_up = 1;
    #1;
    chk("ld_carry",  32'(ld_if.o_carryup), 0);
    chk("ld_borrow", 32'(ld_if.o_borrow), 0);
    tick();
    chk("ld_value", 32'(ld_if.o_value), 23);
    ld_if.i_load_value = 5'd23;
    #1;
    chk("ld_at_max_carry", 32'(ld_if.o_carryup), 0);
    ld_if.i_load = 0;
    ld_if.i_up = 0;
    for (int k = 0; k < 5; k++) tick();
    chk("ld_valid_early", 32'(ld_if.o_bcd_valid), 0);
    tick();
    chk("ld_valid", 32'(ld_if.o_bcd_valid), 1);
    chk("ld_tens",  32'(ld_if.o_tens), 2);
    chk("ld_ones",  32'(ld_if.o_ones), 3);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/time_unit_counter.md
Name: time_unit_counter

Overview:
- One digit-pair counter of the stopwatch/clock datapath (centiseconds, seconds, minutes or hours).
- Consumes the per-unit up/down strobes issued by the stopwatch controller and returns the carry-up it needs to chain the next unit.
- Holds a modulo-(MAX+1) binary count and converts it sequentially to two BCD digits for the display.

Parameters:
- MAX, 59, largest count value; wraps MAX->0 on up and 0->MAX on down; legal range 1..99.
- WIDTH, 7, binary count width; must satisfy 2^WIDTH > MAX.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_up  input  1  increment strobe, one step per cycle high.
- i_down  input  1  decrement strobe, one step per cycle high.
- i_clear  input  1  synchronous clear of count to 0.
- o_value  output  WIDTH  current binary count.
- o_carryup  output  1  combinational: this cycle's increment wraps MAX->0.
- o_borrow  output  1  combinational: this cycle's decrement wraps 0->MAX.
- o_tens  output  4  BCD tens digit of the last converted value.
- o_ones  output  4  BCD ones digit of the last converted value.
- o_bcd_valid  output  1  high when o_tens/o_ones match o_value.

Behaviour:
- Reset (i_rst high at an edge):
  - o_value=0, o_tens=0, o_ones=0, o_bcd_valid=1.
  - Converter returns to IDLE.
  - Reset overrides every other input.
- Update priority per edge: i_rst > i_clear > (i_up, i_down).
  - i_clear: value<=0. No carry or borrow is issued.
  - i_up & ~i_down: value<=value+1, or 0 when value==MAX.
  - i_down & ~i_up: value<=value-1, or MAX when value==0.
  - i_up & i_down: hold. The controller drives both strobes in set mode, and that combination freezes the unit.
  - Neither strobe: hold.
- o_carryup = i_up & ~i_down & ~i_clear & (value==MAX).
  - Purely combinational, so the next unit's up strobe is valid in the same cycle.
  - A cascade of units steps on a single edge; latency 0.
- o_borrow = i_down & ~i_up & ~i_clear & (value==0). Also combinational.
- If value is ever > MAX (not reachable by design), the next up wraps to 0 with carry and the next down loads MAX-1.
- BCD converter FSM (iterative shift-add-3, one bit per cycle):
  - States: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT:
    - Entered on any edge where o_value changes.
    - Captures the new value and clears the scratch BCD registers.
    - o_bcd_valid drops to 0 on that same edge.
  - SHIFT:
    - WIDTH cycles; each cycle adds 3 to any scratch nibble >=5, then shifts one bit in, MSB first.
    - Bit counter runs WIDTH-1 down to 0.
  - SHIFT -> DONE after the final bit. DONE -> IDLE on the next cycle.
    - On the DONE edge o_tens/o_ones load from scratch and o_bcd_valid rises.
    - Conversion latency: WIDTH+1 cycles from the value change to o_bcd_valid=1.
  - If value changes during SHIFT or DONE, the conversion restarts from the new value. o_bcd_valid stays 0 and the old digits are held.
  - Under a continuous stream of changes, o_bcd_valid stays 0 and the digits stay at the last completed conversion.
  - i_clear when value is already 0 is not a change, so no conversion starts.

Optional Feature:
- Macro: TIME_UNIT_COUNTER_LOAD_EN.
- Defined:
  - Adds ports i_load (input, 1) and i_load_value (input, WIDTH).
  - Priority: i_rst > i_clear > i_load > strobes.
  - i_load sets value to i_load_value, clamped to MAX if larger.
  - No carry or borrow is issued on a load cycle; o_carryup and o_borrow are also gated by ~i_load.
  - A load that changes the value starts a conversion.
- Undefined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package time_unit_pkg holds:
  - Constants CS_MAX=99, SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
  - BCD_W=4.
  - The converter state typedef (IDLE/SHIFT/DONE).
- Sub-module bin2bcd_seq contains the shift-add-3 FSM.
  - Interface: start/value in, tens/ones/valid out.
  - time_unit_counter instantiates it and keeps only the count and carry logic.

Test Plan:
- Reset, then i_up for 60 cycles with MAX=59 -> value 0..59; o_carryup=1 only in the cycle value==59 & i_up; value returns to 0; final o_tens=0, o_ones=0 after 8 cycles.
- value=0, i_down one cycle -> o_borrow=1 in that cycle, value=59; o_bcd_valid=0 for 8 cycles, then o_tens=5, o_ones=9.
- value=59, i_up=i_down=1 for 5 cycles -> value stays 59, o_carryup=0, o_borrow=0, o_bcd_valid stays 1.
- value=59, i_up with i_clear=1 -> value=0, o_carryup=0; then i_rst mid-conversion -> all outputs 0, o_bcd_valid=1 next cycle.
- Two chained instances, MAX=99 then MAX=59, lower i_up held: at 99 the upper increments on the same edge; after 6000 cycles both read 0 with one upper carry pulse.
- With TIME_UNIT_COUNTER_LOAD_EN, MAX=23: i_load with i_load_value=30 -> value=23, no carry; o_tens=2, o_ones=3 after WIDTH+1 cycles.
